// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART FIFO core: FSM state encodings,
// counter sizing and parity generation.
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   // Width of a counter that runs 0 .. clks_per_bit-1.
   function automatic int cnt_width(input int clks_per_bit);
      return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
   endfunction

   function automatic logic calc_parity(input logic [7:0] data, input int nbits, input logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < 8; i++) begin
         if (i < nbits) p = p ^ data[i];
         else           p = p;
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; a write on a full FIFO succeeds only when a
// read happens in the same cycle.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             wr_ok_s;
   logic             rd_ok_s;

   assign empty   = (wr_ptr_r == rd_ptr_r);
   assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign rd_ok_s = rd_en && !empty;
   assign wr_ok_s = wr_en && (!full || rd_ok_s);
   assign rd_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

   // Pointer update; the extra MSB distinguishes full from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (rd_ok_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      if (wr_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_fifo_core.sv
// UART transmitter/receiver with a FIFO on each side.
// Optional parity bit is built in when the UART_PARITY_EN macro is defined.
module uart_fifo_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_i,
   output logic                 tx_o,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun,
   output logic                 tx_busy
);

   localparam int CW = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic          PAR_ODD   = (PARITY_ODD != 0);

   // ---------------- TX side ----------------
   tx_state_t            tx_state_r, tx_state_nx_s;
   logic [CW-1:0]        tx_cnt_r, tx_cnt_nx_s;
   logic [2:0]           tx_bit_r, tx_bit_nx_s;
   logic [DATA_BITS-1:0] tx_shreg_r, tx_shreg_nx_s;
   logic                 tx_par_r, tx_par_nx_s;
   logic                 tx_line_r, tx_line_s;
   logic                 tx_load_s, tx_pop_s, tx_bit_end_s;
   logic                 ready_en_r;
   logic [DATA_BITS-1:0] tx_head_s;
   logic                 tx_full_s, tx_empty_s;

   assign tx_ready     = ready_en_r && !tx_full_s;
   assign tx_busy      = (tx_state_r != TX_IDLE) || !tx_empty_s;
   assign tx_o         = tx_line_r;
   assign tx_bit_end_s = (tx_cnt_r == CNT_LAST);

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (tx_valid && tx_ready),
      .wr_data (tx_data),
      .rd_en   (tx_pop_s),
      .rd_data (tx_head_s),
      .full    (tx_full_s),
      .empty   (tx_empty_s)
   );

   // TX state, bit timing and serial line register.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_r <= TX_IDLE;
         tx_cnt_r   <= CNT_ZERO;
         tx_bit_r   <= 3'd0;
         tx_shreg_r <= {DATA_BITS{1'b0}};
         tx_par_r   <= 1'b0;
         tx_line_r  <= 1'b1;
         ready_en_r <= 1'b0;
      end else begin
         tx_state_r <= tx_state_nx_s;
         tx_cnt_r   <= tx_cnt_nx_s;
         tx_bit_r   <= tx_bit_nx_s;
         tx_shreg_r <= tx_shreg_nx_s;
         tx_par_r   <= tx_par_nx_s;
         tx_line_r  <= tx_line_s;
         ready_en_r <= 1'b1;
      end
   end

   // TX next-state; a load from the FIFO starts a frame from IDLE or straight out of STOP.
   always_comb begin
      tx_state_nx_s = tx_state_r;
      tx_cnt_nx_s   = tx_cnt_r;
      tx_bit_nx_s   = tx_bit_r;
      tx_shreg_nx_s = tx_shreg_r;
      tx_par_nx_s   = tx_par_r;
      tx_load_s     = 1'b0;
      case (tx_state_r)
         TX_IDLE: begin
            if (!tx_empty_s) tx_load_s = 1'b1;
            else             tx_load_s = 1'b0;
         end
         TX_START: begin
            if (tx_bit_end_s) begin
               tx_cnt_nx_s   = CNT_ZERO;
               tx_bit_nx_s   = 3'd0;
               tx_state_nx_s = TX_DATA;
            end else begin
               tx_cnt_nx_s = tx_cnt_r + CNT_ONE;
            end
         end
         TX_DATA: begin
            if (tx_bit_end_s) begin
               tx_cnt_nx_s = CNT_ZERO;
               if (tx_bit_r == DATA_LAST) begin
                  tx_bit_nx_s = 3'd0;
`ifdef UART_PARITY_EN
                  tx_state_nx_s = TX_PARITY;
`else
                  tx_state_nx_s = TX_STOP;
`endif
               end else begin
                  tx_bit_nx_s   = tx_bit_r + 3'd1;
                  tx_shreg_nx_s = {1'b0, tx_shreg_r[DATA_BITS-1:1]};
               end
            end else begin
               tx_cnt_nx_s = tx_cnt_r + CNT_ONE;
            end
         end
         TX_PARITY: begin
            if (tx_bit_end_s) begin
               tx_cnt_nx_s   = CNT_ZERO;
               tx_state_nx_s = TX_STOP;
            end else begin
               tx_cnt_nx_s = tx_cnt_r + CNT_ONE;
            end
         end
         TX_STOP: begin
            if (tx_bit_end_s) begin
               tx_cnt_nx_s = CNT_ZERO;
               if (tx_bit_r == STOP_LAST) begin
                  tx_bit_nx_s = 3'd0;
                  if (!tx_empty_s) tx_load_s     = 1'b1;
                  else             tx_state_nx_s = TX_IDLE;
               end else begin
                  tx_bit_nx_s = tx_bit_r + 3'd1;
               end
            end else begin
               tx_cnt_nx_s = tx_cnt_r + CNT_ONE;
            end
         end
         default: tx_state_nx_s = TX_IDLE;
      endcase
      if (tx_load_s) begin
         tx_state_nx_s = TX_START;
         tx_cnt_nx_s   = CNT_ZERO;
         tx_bit_nx_s   = 3'd0;
         tx_shreg_nx_s = tx_head_s;
         tx_par_nx_s   = calc_parity(8'(tx_head_s), DATA_BITS, PAR_ODD);
      end else begin
         tx_load_s = 1'b0;
      end
   end

   // TX outputs: line level follows the state being entered, so it lands one cycle after the pop.
   always_comb begin
      tx_pop_s = tx_load_s;
      case (tx_state_nx_s)
         TX_IDLE:   tx_line_s = 1'b1;
         TX_START:  tx_line_s = 1'b0;
         TX_DATA:   tx_line_s = tx_shreg_nx_s[0];
         TX_PARITY: tx_line_s = tx_par_nx_s;
         TX_STOP:   tx_line_s = 1'b1;
         default:   tx_line_s = 1'b1;
      endcase
   end

   // ---------------- RX side ----------------
   rx_state_t            rx_state_r, rx_state_nx_s;
   logic [CW-1:0]        rx_cnt_r, rx_cnt_nx_s;
   logic [2:0]           rx_bit_r, rx_bit_nx_s;
   logic [DATA_BITS-1:0] rx_shreg_r, rx_shreg_nx_s;
   logic                 rx_par_bad_r, rx_par_bad_nx_s;
   logic                 rx_sync0_r, rx_sync1_r, rx_prev_r;
   logic                 rx_fall_s, rx_bit_end_s, rx_stop_smp_s;
   logic                 rx_good_s, rx_ferr_s;
   logic                 rx_push_r, rx_ferr_r, rx_ovr_r;
   logic [DATA_BITS-1:0] rx_byte_r;
   logic                 rx_full_s, rx_empty_s, rx_pop_s;

   assign rx_fall_s    = rx_prev_r && !rx_sync1_r;
   assign rx_bit_end_s = (rx_cnt_r == CNT_LAST);
   assign rx_valid     = !rx_empty_s;
   assign rx_pop_s     = rx_valid && rx_ready;
   assign rx_frame_err = rx_ferr_r;
   assign rx_overrun   = rx_ovr_r;

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (rx_push_r),
      .wr_data (rx_byte_r),
      .rd_en   (rx_pop_s),
      .rd_data (rx_data),
      .full    (rx_full_s),
      .empty   (rx_empty_s)
   );

   // Input synchroniser and RX state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync0_r   <= 1'b1;
         rx_sync1_r   <= 1'b1;
         rx_prev_r    <= 1'b1;
         rx_state_r   <= RX_IDLE;
         rx_cnt_r     <= CNT_ZERO;
         rx_bit_r     <= 3'd0;
         rx_shreg_r   <= {DATA_BITS{1'b0}};
         rx_par_bad_r <= 1'b0;
      end else begin
         rx_sync0_r   <= rx_i;
         rx_sync1_r   <= rx_sync0_r;
         rx_prev_r    <= rx_sync1_r;
         rx_state_r   <= rx_state_nx_s;
         rx_cnt_r     <= rx_cnt_nx_s;
         rx_bit_r     <= rx_bit_nx_s;
         rx_shreg_r   <= rx_shreg_nx_s;
         rx_par_bad_r <= rx_par_bad_nx_s;
      end
   end

   // RX next-state; an edge-triggered start means a low line after a frame error is ignored until it goes high.
   always_comb begin
      rx_state_nx_s   = rx_state_r;
      rx_cnt_nx_s     = rx_cnt_r;
      rx_bit_nx_s     = rx_bit_r;
      rx_shreg_nx_s   = rx_shreg_r;
      rx_par_bad_nx_s = rx_par_bad_r;
      case (rx_state_r)
         RX_IDLE: begin
            if (rx_fall_s) begin
               rx_state_nx_s = RX_START;
               rx_cnt_nx_s   = CNT_ZERO;
            end else begin
               rx_cnt_nx_s = CNT_ZERO;
            end
         end
         RX_START: begin
            if (rx_cnt_r == CNT_HALF) begin
               rx_cnt_nx_s = CNT_ZERO;
               if (!rx_sync1_r) begin
                  rx_state_nx_s   = RX_DATA;
                  rx_bit_nx_s     = 3'd0;
                  rx_par_bad_nx_s = 1'b0;
               end else begin
                  rx_state_nx_s = RX_IDLE;
               end
            end else begin
               rx_cnt_nx_s = rx_cnt_r + CNT_ONE;
            end
         end
         RX_DATA: begin
            if (rx_bit_end_s) begin
               rx_cnt_nx_s   = CNT_ZERO;
               rx_shreg_nx_s = {rx_sync1_r, rx_shreg_r[DATA_BITS-1:1]};
               if (rx_bit_r == DATA_LAST) begin
                  rx_bit_nx_s = 3'd0;
`ifdef UART_PARITY_EN
                  rx_state_nx_s = RX_PARITY;
`else
                  rx_state_nx_s = RX_STOP;
`endif
               end else begin
                  rx_bit_nx_s = rx_bit_r + 3'd1;
               end
            end else begin
               rx_cnt_nx_s = rx_cnt_r + CNT_ONE;
            end
         end
         RX_PARITY: begin
            if (rx_bit_end_s) begin
               rx_cnt_nx_s     = CNT_ZERO;
               rx_par_bad_nx_s = rx_sync1_r ^ calc_parity(8'(rx_shreg_r), DATA_BITS, PAR_ODD);
               rx_state_nx_s   = RX_STOP;
            end else begin
               rx_cnt_nx_s = rx_cnt_r + CNT_ONE;
            end
         end
         RX_STOP: begin
            if (rx_bit_end_s) begin
               rx_cnt_nx_s   = CNT_ZERO;
               rx_state_nx_s = RX_IDLE;
            end else begin
               rx_cnt_nx_s = rx_cnt_r + CNT_ONE;
            end
         end
         default: rx_state_nx_s = RX_IDLE;
      endcase
   end

   // RX outputs: verdict on the completed frame at the stop-bit sample.
   always_comb begin
      rx_stop_smp_s = (rx_state_r == RX_STOP) && rx_bit_end_s;
      rx_good_s     = rx_stop_smp_s && rx_sync1_r && !rx_par_bad_r;
      rx_ferr_s     = rx_stop_smp_s && !rx_sync1_r;
   end

   // Push register and error pulses; overrun is judged in the push cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_push_r <= 1'b0;
         rx_byte_r <= {DATA_BITS{1'b0}};
         rx_ferr_r <= 1'b0;
         rx_ovr_r  <= 1'b0;
      end else begin
         rx_push_r <= rx_good_s;
         rx_byte_r <= rx_good_s ? rx_shreg_r : rx_byte_r;
         rx_ferr_r <= rx_ferr_s;
         rx_ovr_r  <= rx_push_r && rx_full_s && !rx_pop_s;
      end
   end

`ifdef UART_PARITY_EN
   logic rx_perr_r;

   // Parity error pulse for a frame with a good stop bit.
   always_ff @(posedge clk) begin
      if (rst) rx_perr_r <= 1'b0;
      else     rx_perr_r <= rx_stop_smp_s && rx_sync1_r && rx_par_bad_r;
   end

   assign rx_parity_err = rx_perr_r;
`else
   assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core (CLKS_PER_BIT=4, 8N1, FIFO_DEPTH=4);
// parity cases are included when UART_PARITY_EN is defined.
module tb_uart_fifo_core;

   localparam int CPB = 4;
`ifdef UART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       tx_valid = 1'b0;
   logic       rx_ready = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       rx_line;
   logic       tx_o, tx_ready, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, tx_busy;
   logic [7:0] rx_data;

   int pass_cnt = 0;
   int total_cnt = 0;
   int ferr_cnt = 0;
   int perr_cnt = 0;
   int ovr_cnt = 0;

   assign rx_line = loop_en ? tx_o : rx_drv;

   uart_fifo_core #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8),
      .STOP_BITS    (1),
      .FIFO_DEPTH   (4),
      .PARITY_ODD   (0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_i          (rx_line),
      .tx_o          (tx_o),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err),
      .rx_overrun    (rx_overrun),
      .tx_busy       (tx_busy)
   );

   always #5 clk = ~clk;

   // Count error pulses away from the active edge.
   always @(negedge clk) begin
      ferr_cnt = ferr_cnt + int'(rx_frame_err);
      perr_cnt = perr_cnt + int'(rx_parity_err);
      ovr_cnt  = ovr_cnt + int'(rx_overrun);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      rx_drv = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         tick(CPB);
      end
`ifdef UART_PARITY_EN
      rx_drv = par;
      tick(CPB);
`else
      rx_drv = par & 1'b0;
`endif
      rx_drv = stop;
      tick(CPB);
      rx_drv = 1'b1;
      tick(CPB);
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      int w;
      w = 0;
      while (!rx_valid && w < 200) begin
         tick(1);
         w++;
      end
      check_eq({tag, "_valid"}, 32'(rx_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(rx_data), 32'(exp));
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
   endtask

   initial begin
      logic [10:0] exp_frame;
      logic [7:0]  bytes_q [5];
      logic [7:0]  d;
      int          f0, p0, o0;

      // Reset state
      tick(3);
      check_eq("rst_tx_o", 32'(tx_o), 32'd1);
      check_eq("rst_tx_ready", 32'(tx_ready), 32'd0);
      check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
      check_eq("rst_tx_busy", 32'(tx_busy), 32'd0);
      check_eq("rst_rx_data", 32'(rx_data), 32'd0);
      check_eq("rst_errs", 32'({rx_frame_err, rx_parity_err, rx_overrun}), 32'd0);
      rst = 1'b0;
      tick(1);
      check_eq("tx_ready_after_rst", 32'(tx_ready), 32'd1);

      // Single TX frame of 0xA5
      d = 8'hA5;
      exp_frame = {1'b1, 1'b1, d, 1'b0};
`ifdef UART_PARITY_EN
      exp_frame[9] = ^d;
`endif
      tx_data  = d;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      check_eq("tx_n1_idle", 32'(tx_o), 32'd1);
      check_eq("tx_n1_busy", 32'(tx_busy), 32'd1);
      tick(1);
      for (int k = 0; k < FRAME_BITS * CPB; k++) begin
         check_eq("tx_bit", 32'(tx_o), 32'(exp_frame[k / CPB]));
         tick(1);
      end
      check_eq("tx_after_frame", 32'(tx_o), 32'd1);
      check_eq("tx_busy_after", 32'(tx_busy), 32'd0);

      // Loopback of three bytes
      loop_en = 1'b1;
      bytes_q[0] = 8'h00; bytes_q[1] = 8'hFF; bytes_q[2] = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         tx_data  = bytes_q[i];
         tx_valid = 1'b1;
         tick(1);
      end
      tx_valid = 1'b0;
      pop_check("loop0", 8'h00);
      pop_check("loop1", 8'hFF);
      pop_check("loop2", 8'h3C);
      tick(20);
      loop_en = 1'b0;
      check_eq("loop_errs", 32'(ferr_cnt + perr_cnt + ovr_cnt), 32'd0);

      // Overrun: five frames, no pops
      o0 = ovr_cnt;
      bytes_q[0] = 8'h11; bytes_q[1] = 8'h22; bytes_q[2] = 8'h33;
      bytes_q[3] = 8'h44; bytes_q[4] = 8'h55;
      for (int i = 0; i < 5; i++) send_frame(bytes_q[i], ^bytes_q[i], 1'b1);
      tick(4);
      check_eq("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
      for (int i = 0; i < 4; i++) pop_check("ovr_pop", bytes_q[i]);
      check_eq("ovr_empty", 32'(rx_valid), 32'd0);

      // Glitch and frame error
      f0 = ferr_cnt;
      rx_drv = 1'b0;
      tick(2);
      rx_drv = 1'b1;
      tick(20);
      check_eq("glitch_nopush", 32'(rx_valid), 32'd0);
      check_eq("glitch_noerr", 32'(ferr_cnt - f0), 32'd0);
      d = 8'h5A;
      send_frame(d, ^d, 1'b0);
      tick(4);
      check_eq("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
      check_eq("ferr_nopush", 32'(rx_valid), 32'd0);
      d = 8'hC3;
      send_frame(d, ^d, 1'b1);
      pop_check("recover", 8'hC3);

      // Parity
      p0 = perr_cnt;
`ifdef UART_PARITY_EN
      send_frame(8'h07, 1'b0, 1'b1);
      tick(4);
      check_eq("perr_pulse", 32'(perr_cnt - p0), 32'd1);
      check_eq("perr_nopush", 32'(rx_valid), 32'd0);
      send_frame(8'h07, 1'b1, 1'b1);
      pop_check("par_ok", 8'h07);
      check_eq("par_ok_noerr", 32'(perr_cnt - p0), 32'd1);
`else
      check_eq("perr_tied", 32'(perr_cnt), 32'd0);
`endif

      // TX FIFO fills, then reset mid-frame
      for (int i = 0; i < 5; i++) begin
         tx_data  = 8'(16 + i);
         tx_valid = 1'b1;
         tick(1);
      end
      tx_valid = 1'b0;
      check_eq("tx_full_ready", 32'(tx_ready), 32'd0);
      check_eq("tx_full_busy", 32'(tx_busy), 32'd1);
      tick(6);
      check_eq("pre_rst_tx", 32'(tx_o), 32'd0);
      rst = 1'b1;
      tick(1);
      check_eq("mid_rst_tx_o", 32'(tx_o), 32'd1);
      check_eq("mid_rst_busy", 32'(tx_busy), 32'd0);
      check_eq("mid_rst_ready", 32'(tx_ready), 32'd0);
      rst = 1'b0;
      tick(1);
      check_eq("post_rst_ready", 32'(tx_ready), 32'd1);
      check_eq("post_rst_busy", 32'(tx_busy), 32'd0);
      tick(50);
      check_eq("post_rst_line", 32'(tx_o), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/uart_fifo_core.md
UART_FIFO_CORE -- requirements
Module: uart_fifo_core

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal values are 4..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal values are 5..8.
REQ-003 Parameter STOP_BITS, default 1: stop bits per frame; legal values are 1 or 2.
REQ-004 Parameter FIFO_DEPTH, default 16: entries per FIFO; power of two, 2..256.
REQ-005 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; used only with UART_PARITY_EN.
REQ-006 Port clk, input, 1: single clock for all logic.
REQ-007 Port rst, input, 1: reset, synchronous, active-high.
REQ-008 Port rx_i, input, 1: asynchronous serial input; idle level is high.
REQ-009 Port tx_o, output, 1: serial output; idle level is high.
REQ-010 Port tx_data, input, DATA_BITS: byte to transmit.
REQ-011 Port tx_valid, input, 1 and port tx_ready, output, 1: TX push handshake; tx_ready = TX FIFO not full.
REQ-012 Port rx_data, output, DATA_BITS: head entry of the RX FIFO.
REQ-013 Port rx_valid, output, 1 and port rx_ready, input, 1: RX pop handshake; rx_valid = RX FIFO not empty.
REQ-014 Ports rx_frame_err, rx_parity_err and rx_overrun, outputs, 1 each: one-cycle error pulses.
REQ-015 Port tx_busy, output, 1: high while the TX FSM is not IDLE or the TX FIFO is non-empty.

Function
REQ-016 A TX push occurs on any cycle with tx_valid and tx_ready both high; an RX pop occurs on any cycle with rx_valid and rx_ready both high.
REQ-017 TX FSM states are IDLE, START, DATA, PARITY, STOP; each bit is held for exactly CLKS_PER_BIT cycles.
REQ-018 Data bits are sent LSB first; PARITY is skipped when parity is compiled out; STOP lasts STOP_BITS bit times.
REQ-019 Push at cycle N into an empty FIFO with the FSM in IDLE: FSM pops at N+1, tx_o drives low (registered) at N+2.
REQ-020 After STOP, if the TX FIFO is non-empty, START follows back-to-back with no extra idle cycle.
REQ-021 rx_i passes through a 2-flop synchroniser before any use.
REQ-022 RX FSM states are IDLE, START, DATA, PARITY, STOP.
REQ-023 IDLE to START on a synchronised falling edge.
REQ-024 The start bit is sampled at CLKS_PER_BIT/2; a high sample there is a false start and returns the FSM to IDLE with no push.
REQ-025 After a valid start, each subsequent bit is sampled once at its mid-point, one sample every CLKS_PER_BIT cycles.
REQ-026 The RX FSM checks only the first stop bit; it re-arms in IDLE immediately after that sample.
REQ-027 First stop bit sampled low: rx_frame_err pulses, the byte is discarded, and the FSM waits in IDLE for the line to return high before re-arming.
REQ-028 Parity mismatch: rx_parity_err pulses and the byte is discarded.
REQ-029 A good byte is pushed to the RX FIFO the cycle after the stop-bit sample; rx_valid rises one cycle later.
REQ-030 Good byte completing with the RX FIFO full and no pop that cycle: byte dropped, rx_overrun pulses, FIFO contents unchanged.
REQ-031 Push and pop in the same cycle on a full RX FIFO: both succeed and the count is unchanged.
REQ-032 FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full = MSBs differ and the remaining bits are equal.

Reset
REQ-033 On rst: both FSMs go to IDLE, all counters and FIFO pointers clear, and both synchroniser flops set to 1.
REQ-034 On rst: tx_o=1, tx_ready=0 during reset then 1, rx_valid=0, all error pulses=0, tx_busy=0, rx_data=0.
REQ-035 rst mid-frame aborts the frame; tx_o returns high on the next cycle and partial RX data is discarded.

Configuration
REQ-036 Macro UART_PARITY_EN defined: one parity bit per PARITY_ODD is generated on TX and checked on RX.
REQ-037 Macro UART_PARITY_EN undefined: no parity bit and no PARITY state; rx_parity_err is tied to 0.

Structure
REQ-038 Package uart_pkg holds the TX/RX FSM state typedefs and the function computing the bit-counter width from CLKS_PER_BIT.
REQ-039 Sub-module uart_fifo (synchronous FIFO, parameters WIDTH and DEPTH) is instantiated twice, once for TX and once for RX.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4)
REQ-040 Push 0xA5 -> tx_o low at N+2, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high; without parity the frame is 40 cycles.
REQ-041 Loop tx_o to rx_i and push 0x00, 0xFF, 0x3C -> rx_data pops the same 3 bytes in order with no error pulses.
REQ-042 Drive 5 good frames into rx_i with no pop -> 4 entries stored and rx_overrun pulses once on the 5th frame.
REQ-043 2-cycle low glitch on rx_i -> no push and no error pulse; a frame with stop bit low -> rx_frame_err pulse and no push.
REQ-044 With UART_PARITY_EN, even parity, receive 0x07 with parity bit 0 -> rx_parity_err pulse; with parity bit 1 -> accepted.
REQ-045 Assert rst mid TX frame -> tx_o=1 next cycle, tx_busy=0, and TX FIFO empty.
